// File: rtl/shifter_pkg.sv
// Shared constants for the pipelined barrel shifter: in_op bit positions,
// op encodings and the default data width.
package shifter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned OP_W          = 3;

    localparam int unsigned OP_DIR_BIT  = 0;
    localparam int unsigned OP_TYPE_BIT = 1;
    localparam int unsigned OP_ROT_BIT  = 2;

    localparam logic [OP_W-1:0] OP_SLL = 3'b000;
    localparam logic [OP_W-1:0] OP_SRL = 3'b001;
    localparam logic [OP_W-1:0] OP_SRA = 3'b011;
    localparam logic [OP_W-1:0] OP_ROL = 3'b100;
    localparam logic [OP_W-1:0] OP_ROR = 3'b101;

endpackage

// File: rtl/shift_stage.sv
// One registered barrel-shifter stage: shifts by 2^K when shamt bit K is set.
// Rotate support is compiled in only when PIPELINED_SHIFTER_ROTATE_EN is defined.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned K     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       up_valid,
    input  logic [WIDTH-1:0]           up_data,
    input  logic                       up_carry,
    input  logic [$clog2(WIDTH)-1:0]   up_shamt,
    input  logic [OP_W-1:0]            up_op,
    output logic                       valid,
    output logic [WIDTH-1:0]           data,
    output logic                       carry,
    output logic                       zero,
    output logic [$clog2(WIDTH)-1:0]   shamt,
    output logic [OP_W-1:0]            op
);

    localparam int unsigned S = 1 << K;

    logic             dir;
    logic             arith;
    logic [WIDTH-1:0] next_data;
    logic             next_carry;

    assign dir   = up_op[OP_DIR_BIT];
    assign arith = up_op[OP_TYPE_BIT];

    // The carry tracks the last bit crossing the word boundary; for a rotate
    // that bit lands in out_data[0]/[WIDTH-1], so one formula serves both.
    always_comb begin
        next_data  = up_data;
        next_carry = up_carry;
        if (up_shamt[K]) begin
            if (!dir) begin
                next_data  = up_data << S;
                next_carry = up_data[WIDTH-S];
`ifdef PIPELINED_SHIFTER_ROTATE_EN
                if (up_op[OP_ROT_BIT]) begin
                    next_data = (up_data << S) | (up_data >> (WIDTH - S));
                end
`endif
            end else begin
                if (arith) begin
                    next_data = $signed(up_data) >>> S;
                end else begin
                    next_data = up_data >> S;
                end
                next_carry = up_data[S-1];
`ifdef PIPELINED_SHIFTER_ROTATE_EN
                if (up_op[OP_ROT_BIT]) begin
                    next_data = (up_data >> S) | (up_data << (WIDTH - S));
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
            shamt <= '0;
            op    <= '0;
        end else if (en) begin
            valid <= up_valid;
            data  <= next_data;
            carry <= next_carry;
            zero  <= (next_data == '0);
            shamt <= up_shamt;
            op    <= up_op;
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Log2(WIDTH)-deep pipelined barrel shifter with valid/ready handshake and global stall.
// Optional rotate support: define PIPELINED_SHIFTER_ROTATE_EN.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned  WIDTH = DEFAULT_WIDTH,
    localparam int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero
);

    logic [SHW:0]     pipe_valid;
    logic [SHW:0]     pipe_carry;
    logic [SHW:1]     pipe_zero;
    logic [WIDTH-1:0] pipe_data  [SHW+1];
    logic [SHW-1:0]   pipe_shamt [SHW+1];
    logic [OP_W-1:0]  pipe_op    [SHW+1];
    logic             advance;
    logic             unused_ctl;

    // Whole pipeline moves together; a blocked output freezes every stage.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign pipe_valid[0] = in_valid;
    assign pipe_data[0]  = in_data;
    assign pipe_carry[0] = 1'b0;
    assign pipe_shamt[0] = in_shamt;
    assign pipe_op[0]    = in_op;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (advance),
            .up_valid (pipe_valid[k]),
            .up_data  (pipe_data[k]),
            .up_carry (pipe_carry[k]),
            .up_shamt (pipe_shamt[k]),
            .up_op    (pipe_op[k]),
            .valid    (pipe_valid[k+1]),
            .data     (pipe_data[k+1]),
            .carry    (pipe_carry[k+1]),
            .zero     (pipe_zero[k+1]),
            .shamt    (pipe_shamt[k+1]),
            .op       (pipe_op[k+1])
        );
    end

    assign out_valid = pipe_valid[SHW];
    assign out_data  = pipe_data[SHW];
    assign out_carry = pipe_carry[SHW];
    assign out_zero  = pipe_zero[SHW];

    // Intermediate zero flags and the final control copy have no consumer.
    assign unused_ctl = ^{pipe_zero[SHW-1:1], pipe_shamt[SHW], pipe_op[SHW]};

endmodule
